load_store_unit: RTL and testbench

//  MEM-stage data-memory access unit of the RISC-V core. Takes load/store commands from EX and

---
 rtl/lsu_pkg.sv | 16 +
 rtl/load_align.sv | 26 ++
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// funct3 width codes and the access FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/load_align.sv
// Load data aligner: shifts the addressed lane down, then sign/zero-extends.
// Ports: rdata (word), offset (addr[1:0]), funct3 (width/sign) -> data (32b).
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] lane;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        data = lane;
        case (funct3)
            F3_B:    data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   data = {24'd0, lane[7:0]};
            F3_HU:   data = {16'd0, lane[15:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: legality check, req/ack handshake with data
// memory, pipeline stall, load alignment, access and timeout error pulses.
// Ports: clk, rst_n (sync, active-low); EX command (ex_valid, mem_read,
// mem_write, funct3, addr, store_data); stall; dmem_* request/response;
// load_data/load_valid to write-back; mem_done, access_err, timeout_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        mem_done,
    output logic        access_err,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        mem_done_q, mem_done_d;
    logic        access_err_q, access_err_d;
    logic        timeout_err_q, timeout_err_d;

    logic        is_b, is_h, is_w, f3_ok, illegal;
    logic        access, start, timeout_hit;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] aligned;

    // Offset comes from the address latched at start, not the live EX bus.
    load_align u_align (
        .rdata  (dmem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (aligned)
    );

    always_comb begin
        is_b    = (funct3 == F3_B) || (funct3 == F3_BU);
        is_h    = (funct3 == F3_H) || (funct3 == F3_HU);
        is_w    = (funct3 == F3_W);
        f3_ok   = is_b || is_h || is_w;
        illegal = (mem_read && mem_write)
               || !f3_ok
               || (((funct3 == F3_BU) || (funct3 == F3_HU)) && mem_write)
               || (is_h && addr[0])
               || (is_w && (addr[1:0] != 2'b00));
        access      = ex_valid && (mem_read || mem_write);
        start       = (state_q == IDLE) && access && !illegal;
        timeout_hit = (cnt_q == CW'(TIMEOUT));
        stall       = start
                   || ((state_q == BUSY) && !dmem_ack && !timeout_hit);
    end

    // Byte lanes replicate store data so memory picks it up by be alone.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = store_data;
        if (is_b) begin
            be_n    = 4'b0001 << addr[1:0];
            wdata_n = {4{store_data[7:0]}};
        end else if (is_h) begin
            be_n    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{store_data[15:0]}};
        end
        if (!mem_write) begin
            wdata_n = 32'd0;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        f3_d          = f3_q;
        load_data_d   = load_data_q;
        load_valid_d  = 1'b0;
        mem_done_d    = 1'b0;
        access_err_d  = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                access_err_d = access && illegal;
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = addr;
                    be_d    = be_n;
                    wdata_d = wdata_n;
                    f3_d    = funct3;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    mem_done_d = 1'b1;
                    if (!we_q) begin
                        load_data_d  = aligned;
                        load_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    req_d         = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 32'd0;
            be_q          <= 4'd0;
            wdata_q       <= 32'd0;
            f3_q          <= 3'd0;
            load_data_q   <= 32'd0;
            load_valid_q  <= 1'b0;
            mem_done_q    <= 1'b0;
            access_err_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            f3_q          <= f3_d;
            load_data_q   <= load_data_d;
            load_valid_q  <= load_valid_d;
            mem_done_q    <= mem_done_d;
            access_err_q  <= access_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = {addr_q[31:2], 2'b00};
    assign dmem_be     = be_q;
    assign dmem_wdata  = wdata_q;
    assign load_data   = load_data_q;
    assign load_valid  = load_valid_q;
    assign mem_done    = mem_done_q;
    assign access_err  = access_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (TIMEOUT=4).
// Linear stimulus with immediate assertions and a final summary line.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata, load_data;
    logic        load_valid, mem_done, access_err, timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .load_data  (load_data),
        .load_valid (load_valid),
        .mem_done   (mem_done),
        .access_err (access_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        ex_valid   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    task automatic idle_in();
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_lv", load_valid, 0);
        chk("rst_done", mem_done, 0);
        chk("rst_be", dmem_be, 0);
        rst_n = 1'b1;
        tick();

        // LB 0x103, ack one cycle after req
        issue(1, 0, 3'b000, 32'h103, 0);
        #1 chk("lb_stall_T", stall, 1);
        tick(); idle_in();
        #1;
        chk("lb_req", dmem_req, 1);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_be", dmem_be, 4'b1000);
        chk("lb_we", dmem_we, 0);
        chk("lb_stall_T1", stall, 1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234;
        #1 chk("lb_stall_ack", stall, 0);
        chk("lb_lv_early", load_valid, 0);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        chk("lb_lv", load_valid, 1);
        chk("lb_ld", load_data, 32'hFFFF_FF80);
        chk("lb_done", mem_done, 1);
        chk("lb_req_drop", dmem_req, 0);
        tick();
        chk("lb_lv_pulse", load_valid, 0);

        // LHU 0x202, minimum latency
        issue(1, 0, 3'b101, 32'h202, 0);
        #1 chk("lhu_stall_T", stall, 1);
        tick(); idle_in();
        dmem_ack = 1'b1; dmem_rdata = 32'hBEEF_0000;
        #1;
        chk("lhu_be", dmem_be, 4'b1100);
        chk("lhu_stall_T1", stall, 0);
        tick();
        dmem_ack = 1'b0;
        chk("lhu_lv_T2", load_valid, 1);
        chk("lhu_ld", load_data, 32'h0000_BEEF);

        // LH same word
        issue(1, 0, 3'b001, 32'h202, 0);
        tick(); idle_in();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("lh_ld", load_data, 32'hFFFF_BEEF);

        // SB 0x001
        issue(0, 1, 3'b000, 32'h001, 32'h0000_00AB);
        tick(); idle_in();
        chk("sb_be", dmem_be, 4'b0010);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        chk("sb_addr", dmem_addr, 32'h0);
        chk("sb_we", dmem_we, 1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("sb_done", mem_done, 1);
        chk("sb_lv", load_valid, 0);
        chk("sb_ld_hold", load_data, 32'hFFFF_BEEF);

        // SH 0x002
        issue(0, 1, 3'b001, 32'h002, 32'h1234_CAFE);
        tick(); idle_in();
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hCAFE_CAFE);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("sh_done", mem_done, 1);

        // Illegal: LW 0x006
        issue(1, 0, 3'b010, 32'h006, 0);
        #1 chk("lw_mis_stall", stall, 0);
        tick(); idle_in();
        chk("lw_mis_err", access_err, 1);
        chk("lw_mis_req", dmem_req, 0);
        tick();
        chk("lw_mis_pulse", access_err, 0);

        // Illegal: funct3 011
        issue(1, 0, 3'b011, 32'h0, 0);
        #1 chk("f3_stall", stall, 0);
        tick(); idle_in();
        chk("f3_err", access_err, 1);
        chk("f3_req", dmem_req, 0);

        // Illegal: read and write together
        issue(1, 1, 3'b010, 32'h0, 0);
        #1 chk("rw_stall", stall, 0);
        tick(); idle_in();
        chk("rw_err", access_err, 1);
        chk("rw_req", dmem_req, 0);
        tick();

        // Timeout, no ack
        issue(1, 0, 3'b010, 32'h10, 0);
        #1 chk("to_stall_T", stall, 1);
        tick(); idle_in();
        for (int i = 1; i <= 4; i++) begin
            chk("to_stall_busy", stall, 1);
            tick();
        end
        chk("to_stall_last", stall, 0);
        chk("to_req_last", dmem_req, 1);
        tick();
        chk("to_err", timeout_err, 1);
        chk("to_req_drop", dmem_req, 0);
        chk("to_done", mem_done, 0);
        chk("to_ld_hold", load_data, 32'hFFFF_BEEF);
        tick();
        chk("to_err_pulse", timeout_err, 0);

        // Ack coincides with count==TIMEOUT
        issue(1, 0, 3'b010, 32'h10, 0);
        tick(); idle_in();
        repeat (4) tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        #1 chk("race_stall", stall, 0);
        tick();
        dmem_ack = 1'b0;
        chk("race_done", mem_done, 1);
        chk("race_to", timeout_err, 0);
        chk("race_lv", load_valid, 1);
        chk("race_ld", load_data, 32'h1234_5678);

        // Reset two cycles into BUSY
        issue(1, 0, 3'b010, 32'h20, 0);
        tick(); idle_in();
        tick();
        rst_n = 1'b0;
        #1 chk("rb_req_pre", dmem_req, 1);
        tick();
        rst_n = 1'b1;
        chk("rb_req", dmem_req, 0);
        chk("rb_ld", load_data, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1 chk("rb_stall", stall, 0);
        tick();
        dmem_ack = 1'b0;
        chk("rb_done", mem_done, 0);
        chk("rb_lv", load_valid, 0);
        chk("rb_ld_after", load_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
